gmii_frame_tx: RTL and testbench

//  Transmit-side framer: takes one frame payload (dst MAC .. end of payload) as a byte stream and drives a GMII TX port.

---
 rtl/gmii_frame_tx.sv | 174 +++++++++++++++++
 tb/tb_gmii_frame_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap.
// Latency: first 0x55 one cycle after s_valid is seen in IDLE; an accepted payload byte is driven on the accept edge.
// Backpressure: s_ready only in DATA/ABORT; a missing byte in DATA aborts the frame (underflow), no stall.
module gmii_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_err,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_dv,
  output logic        gmii_tx_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, PAD, FCS, ABORT, IFG
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  // The IDLE cycle that follows IFG also shows dv=0, so IFG itself runs one
  // cycle short; that keeps the gap at exactly IFG_BYTES when a frame is waiting.
  localparam logic [7:0]  IFG_LAST = 8'((IFG_BYTES > 1) ? IFG_BYTES - 2 : 0);
  localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  state_t      state, state_n;
  logic [7:0]  aux, aux_n;          // preamble / FCS byte / IFG cycle counter
  logic [9:0]  cnt, cnt_n;          // payload + pad bytes, saturating
  logic [31:0] crc, crc_n;
  logic [7:0]  txd_n;
  logic        dv_n, err_n;
  logic [15:0] fc_n;
  logic [10:0] cnt_inc;
  logic [9:0]  cnt_sat;
  logic [31:0] crc_inv;
  state_t      after_fcs;

  // Reflected CRC-32, one byte processed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_inc   = {1'b0, cnt} + 11'd1;
  assign cnt_sat   = (cnt == 10'h3FF) ? cnt : cnt_inc[9:0];
  assign crc_inv   = ~crc;
  assign after_fcs = (IFG_BYTES > 1) ? IFG : IDLE;
  assign s_ready   = (state == DATA) || (state == ABORT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and the next values of the registered GMII outputs and datapath.
  always_comb begin
    state_n = state;
    aux_n   = aux;
    cnt_n   = cnt;
    crc_n   = crc;
    fc_n    = frame_count;
    txd_n   = 8'h00;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_n = PRE;
          aux_n   = 8'd0;
          cnt_n   = 10'd0;
          crc_n   = 32'hFFFFFFFF;
        end
      end
      PRE: begin
        txd_n = 8'h55;
        dv_n  = 1'b1;
        aux_n = aux + 8'd1;
        if (aux == PRE_LAST) state_n = SFD;
      end
      SFD: begin
        txd_n   = 8'hD5;
        dv_n    = 1'b1;
        state_n = DATA;
      end
      DATA: begin
        dv_n = 1'b1;
        if (s_valid) begin
          txd_n = s_data;
          err_n = s_err;
          crc_n = crc_byte(crc, s_data);
          cnt_n = cnt_sat;
          if (s_last) begin
            aux_n   = 8'd0;
            state_n = (cnt_inc < MIN_L) ? PAD : FCS;
          end
        end else begin
          // Underflow: poison the frame with one errored byte and stop.
          err_n   = 1'b1;
          state_n = ABORT;
        end
      end
      PAD: begin
        dv_n  = 1'b1;
        crc_n = crc_byte(crc, 8'h00);
        cnt_n = cnt_sat;
        if (cnt_inc >= MIN_L) begin
          aux_n   = 8'd0;
          state_n = FCS;
        end
      end
      FCS: begin
        dv_n  = 1'b1;
        aux_n = aux + 8'd1;
        case (aux[1:0])
          2'd0:    txd_n = crc_inv[7:0];
          2'd1:    txd_n = crc_inv[15:8];
          2'd2:    txd_n = crc_inv[23:16];
          default: txd_n = crc_inv[31:24];
        endcase
        if (aux[1:0] == 2'd3) begin
          fc_n    = frame_count + 16'd1;
          aux_n   = 8'd0;
          state_n = after_fcs;
        end
      end
      ABORT: begin
        // Drain the rest of the broken frame up to its last byte.
        if (s_valid && s_last) begin
          aux_n   = 8'd0;
          state_n = after_fcs;
        end
      end
      IFG: begin
        aux_n = aux + 8'd1;
        if (aux >= IFG_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered GMII outputs, counters and CRC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gmii_txd    <= 8'h00;
      gmii_tx_dv  <= 1'b0;
      gmii_tx_err <= 1'b0;
      frame_count <= 16'd0;
      aux         <= 8'd0;
      cnt         <= 10'd0;
      crc         <= 32'hFFFFFFFF;
    end else begin
      gmii_txd    <= txd_n;
      gmii_tx_dv  <= dv_n;
      gmii_tx_err <= err_n;
      frame_count <= fc_n;
      aux         <= aux_n;
      cnt         <= cnt_n;
      crc         <= crc_n;
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Bench for gmii_frame_tx: two instances (default padding, and padding off).
// Expected GMII byte streams, frame lengths, counts and gaps are queued at issue time.
// A negedge monitor pops and compares whenever tx_dv is high or a frame ends.
`timescale 1ns/1ps
module tb_gmii_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_data  [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic        s_err   [2];
  logic        s_ready [2];
  logic [7:0]  txd     [2];
  logic        dv      [2];
  logic        er      [2];
  logic [15:0] fc      [2];

  gmii_frame_tx #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12)) dut0 (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_err(s_err[0]), .s_ready(s_ready[0]), .gmii_txd(txd[0]), .gmii_tx_dv(dv[0]),
    .gmii_tx_err(er[0]), .frame_count(fc[0]));

  gmii_frame_tx #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_BYTES(12)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_err(s_err[1]), .s_ready(s_ready[1]), .gmii_txd(txd[1]), .gmii_tx_dv(dv[1]),
    .gmii_tx_err(er[1]), .frame_count(fc[1]));

  int         minf [2] = '{60, 0};
  logic [8:0] exp_q [2][$];   // {err, txd} for every dv=1 cycle
  int         len_q [2][$];   // dv cycles per frame
  int         fc_q  [2][$];   // frame_count after the frame
  int         gap_q [2][$];   // required dv=0 gap before the frame, -1 = unchecked
  int         exp_fc [2];
  bit         in_frame [2];
  int         dvcnt [2];
  int         gap [2];
  int         rdy_cnt [2];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // FCS as transmitted: complement of the reflected CRC-32 over the byte list.
  function automatic logic [31:0] fcs32(input byte unsigned b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[j]) begin
      c = c ^ {24'd0, b[j]};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Monitor: compare each GMII byte, and frame length / count / gap at frame boundaries.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_ready[k]) rdy_cnt[k]++;
      if (dv[k]) begin
        if (!in_frame[k]) begin
          in_frame[k] = 1'b1;
          dvcnt[k] = 0;
          if (gap_q[k].size() > 0) begin
            int g;
            g = gap_q[k].pop_front();
            if (g >= 0) chk("ifg_gap", gap[k], g);
          end
        end
        dvcnt[k]++;
        if (exp_q[k].size() == 0) fail_now("unexpected_tx_byte");
        else chk("tx_byte", {er[k], txd[k]}, exp_q[k].pop_front());
      end else begin
        if (in_frame[k]) begin
          in_frame[k] = 1'b0;
          gap[k] = 0;
          if (len_q[k].size() > 0) chk("dv_length", dvcnt[k], len_q[k].pop_front());
          else fail_now("unexpected_frame");
          if (fc_q[k].size() > 0) chk("frame_count", fc[k], fc_q[k].pop_front());
        end
        gap[k]++;
      end
    end
  end

  // mode: 0 random payload, 1 ASCII "123456789..." with known FCS, 2 bytes of 0xAB.
  task automatic send_frame(input int k, input int mode, input int len, input int under_at,
                            input int err_at, input int gap_exp, input bit hold);
    byte unsigned pl[$];
    byte unsigned body[$];
    logic [31:0] c;
    int nexp;
    int t;
    bit r;
    for (int i = 0; i < len; i++)
      pl.push_back((mode == 1) ? 8'(8'h31 + i) : (mode == 2) ? 8'hAB : 8'($urandom_range(0, 255)));
    for (int i = 0; i < 7; i++) exp_q[k].push_back({1'b0, 8'h55});
    exp_q[k].push_back({1'b0, 8'hD5});
    if (under_at > 0) begin
      for (int i = 0; i < under_at; i++) exp_q[k].push_back({i == err_at, pl[i]});
      exp_q[k].push_back({1'b1, 8'h00});
      nexp = 8 + under_at + 1;
    end else begin
      body = pl;
      for (int i = 0; i < len; i++) exp_q[k].push_back({i == err_at, pl[i]});
      while (body.size() < minf[k]) begin
        body.push_back(8'h00);
        exp_q[k].push_back({1'b0, 8'h00});
      end
      c = (mode == 1) ? 32'hCBF43926 : fcs32(body);
      for (int b = 0; b < 4; b++) exp_q[k].push_back({1'b0, c[8*b +: 8]});
      nexp = 8 + body.size() + 4;
      exp_fc[k] = (exp_fc[k] + 1) % 65536;
    end
    len_q[k].push_back(nexp);
    fc_q[k].push_back(exp_fc[k]);
    gap_q[k].push_back(gap_exp);
    for (int i = 0; i < len; i++) begin
      if (under_at > 0 && i == under_at) begin
        s_valid[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      s_valid[k] = 1'b1;
      s_data[k]  = pl[i];
      s_last[k]  = (i == len - 1);
      s_err[k]   = (i == err_at);
      t = 0;
      r = 1'b0;
      while (!r && t < 3000) begin
        @(negedge clk);
        r = s_ready[k];
        @(posedge clk);
        #1;
        t++;
      end
      if (!r) begin
        fail_now("handshake_timeout");
        s_valid[k] = 1'b0;
        return;
      end
    end
    if (!hold) begin
      s_valid[k] = 1'b0;
      s_last[k]  = 1'b0;
      s_err[k]   = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while ((exp_q[k].size() > 0 || len_q[k].size() > 0 || in_frame[k]) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int len, und, err, gp;
    bit hold, ph;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_data[k] = 8'h00; s_valid[k] = 1'b0; s_last[k] = 1'b0; s_err[k] = 1'b0;
      exp_fc[k] = 0; in_frame[k] = 1'b0; dvcnt[k] = 0; gap[k] = 0; rdy_cnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_txd", txd[0], 0);
    chk("reset_dv", dv[0], 0);
    chk("reset_err", er[0], 0);
    chk("reset_ready", s_ready[0], 0);
    chk("reset_count", fc[0], 0);
    chk("reset_dv1", dv[1], 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Known-answer frame with padding disabled.
    send_frame(1, 1, 9, 0, -1, -1, 1'b0);
    wait_idle(1);

    // One-byte payload padded to minimum length.
    rdy_cnt[0] = 0;
    send_frame(0, 2, 1, 0, -1, -1, 1'b0);
    wait_idle(0);
    chk("ready_cycles_1byte", rdy_cnt[0], 1);

    // Back-to-back 64-byte frames with s_valid held high.
    send_frame(0, 0, 64, 0, -1, -1, 1'b1);
    send_frame(0, 0, 64, 0, -1, 12, 1'b0);
    wait_idle(0);

    // Underflow after the 10th byte, then drain to s_last.
    send_frame(0, 0, 20, 10, -1, -1, 1'b0);
    wait_idle(0);

    // Corrupt 5th payload byte.
    send_frame(0, 0, 30, 0, 4, -1, 1'b0);
    wait_idle(0);

    // Randomized frames.
    ph = 1'b0;
    for (int n = 0; n < 8; n++) begin
      len  = $urandom_range(2, 100);
      und  = (n == 3) ? $urandom_range(1, len - 1) : 0;
      err  = $urandom_range(0, len);
      hold = (und == 0 && n != 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      gp   = ph ? 12 : -1;
      send_frame(0, 0, len, und, err, gp, hold);
      ph = hold;
      if (!hold) begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
    end
    wait_idle(0);
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(1, 80);
      send_frame(1, 0, len, 0, $urandom_range(0, len), -1, 1'b0);
    end
    wait_idle(1);

    // Reset asserted while padding a short frame.
    send_frame(0, 0, 3, 0, -1, -1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_dv", dv[0], 0);
    chk("midreset_err", er[0], 0);
    chk("midreset_txd", txd[0], 0);
    chk("midreset_count", fc[0], 0);
    chk("midreset_ready", s_ready[0], 0);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete(); len_q[k].delete(); fc_q[k].delete(); gap_q[k].delete();
      in_frame[k] = 1'b0;
      exp_fc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0, 0, 15, 0, -1, -1, 1'b0);
    wait_idle(0);
    send_frame(1, 0, 40, 0, -1, -1, 1'b0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
